// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes, with sign correction folded into the final step.
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      mdOp,
  input  logic [XLEN-1:0] mdIn1,
  input  logic [XLEN-1:0] mdIn2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] mdOut,
  output logic            busy
);

  // state | meaning
  // IDLE  | waiting for a request
  // CALC  | one multiply/divide iteration per cycle
  // DONE  | result held until out_ready
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0] SAT  = CW'(XLEN);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [2:0]          op;
  logic [XLEN-1:0]     opnd;
  logic [2*XLEN-1:0]   p;
  logic                neg_q;
  logic                neg_r;
  logic [XLEN-1:0]     res;

  logic                is_div, sgn1, sgn2, neg1, neg2, div_zero, ovf;
  logic [XLEN-1:0]     mag1, mag2;
  logic [XLEN:0]       sum, rs, diff;
  logic [2*XLEN-1:0]   p_nxt, prod_s;
  logic [XLEN-1:0]     quot, rem, res_fin;

  always_comb begin
    is_div   = mdOp[2];
    sgn1     = is_div ? !mdOp[0] : (mdOp != 3'd3);
    sgn2     = is_div ? !mdOp[0] : !mdOp[1];
    neg1     = sgn1 && mdIn1[XLEN-1];
    neg2     = sgn2 && mdIn2[XLEN-1];
    mag1     = neg1 ? -mdIn1 : mdIn1;
    mag2     = neg2 ? -mdIn2 : mdIn2;
    div_zero = (mdIn2 == '0);
    ovf      = !mdOp[0] && (mdIn1 == {1'b1, {(XLEN-1){1'b0}}}) && (mdIn2 == '1);
  end

  // One iteration: shift-add when multiplying, trial subtract when dividing.
  always_comb begin
    sum  = {1'b0, p[2*XLEN-1:XLEN]} + {1'b0, (p[0] ? opnd : {XLEN{1'b0}})};
    rs   = {p[2*XLEN-1:XLEN], p[XLEN-1]};
    diff = rs - {1'b0, opnd};
    if (!op[2])
      p_nxt = {sum, p[XLEN-1:1]};
    else if (diff[XLEN])
      p_nxt = {rs[XLEN-1:0], p[XLEN-2:0], 1'b0};
    else
      p_nxt = {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
    prod_s = neg_q ? -p_nxt : p_nxt;
    quot   = p_nxt[XLEN-1:0];
    rem    = p_nxt[2*XLEN-1:XLEN];
    if (!op[2])
      res_fin = (op == 3'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else if (op[1])
      res_fin = neg_r ? -rem : rem;
    else
      res_fin = neg_q ? -quot : quot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= '0;
      opnd  <= '0;
      p     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      res   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && !flush) begin
          op    <= mdOp;
          cnt   <= '0;
          neg_q <= neg1 ^ neg2;
          neg_r <= neg1;
          if (is_div && div_zero) begin
            state <= DONE;
            res   <= mdOp[1] ? mdIn1 : {XLEN{1'b1}};
          end else if (is_div && ovf) begin
            state <= DONE;
            res   <= mdOp[1] ? {XLEN{1'b0}} : mdIn1;
          end else begin
            state <= CALC;
            opnd  <= is_div ? mag2 : mag1;
            p     <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
          end
        end
        CALC: if (flush) begin
          state <= IDLE;
        end else begin
          p   <= p_nxt;
          cnt <= (cnt == SAT) ? cnt : cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            res   <= res_fin;
          end
        end
        DONE: if (flush || out_ready) begin
          state <= IDLE;
          res   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign mdOut     = res;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq (XLEN=32): directed vectors push expected results,
// a negedge monitor checks result value and first-valid latency.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0]  mdOp;
  logic [31:0] mdIn1, mdIn2, mdOut;

  mdu_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mdOp(mdOp), .mdIn1(mdIn1), .mdIn2(mdIn2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .mdOut(mdOut), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   prev_v = 1'b0;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3,
                         DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: latency on the first valid cycle, value on the handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL spurious_valid: out_valid=1 with nothing outstanding, required 0");
        end else if (cyc - sb[0].acc != sb[0].lat) begin
          n_err++;
          $display("FAIL %s_latency: got %0d cycles, required %0d", sb[0].name,
                   cyc - sb[0].acc, sb[0].lat);
        end
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk(e.name, mdOut, e.data);
      end
      prev_v = out_valid;
    end
  end

  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e, input int lat, input bit keep);
    int n = 0;
    @(negedge clk);
    mdOp = op; mdIn1 = a; mdIn2 = b; in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL %s_accept: in_ready stayed 0 for %0d cycles, required 1", name, n);
      in_valid = 1'b0;
      return;
    end
    if (keep) sb.push_back('{e, lat, cyc, name});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mdIn1 = $urandom;
    mdIn2 = $urandom;
    mdOp  = 3'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    mdOp = '0; mdIn1 = '0; mdIn2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mdout", mdOut, 32'd0);

    issue("mul_7_m3",   MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1);
    issue("mulh_min",   MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, 1);
    issue("mulhu_min",  MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 33, 1);
    issue("mulhsu_m1",  MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1);
    issue("mulhu_max",  MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1);
    issue("divu_by0",   DIVU,   32'd100,      32'd0,        32'hFFFFFFFF, 1, 1);
    issue("rem_by0",    REM,    32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 1, 1);
    issue("div_ovf",    DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1);
    issue("rem_ovf",    REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1);
    issue("div_m7_2",   DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1);
    issue("rem_m7_2",   REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1);
    issue("divu_100_7", DIVU,   32'd100,      32'd7,        32'd14,       33, 1);
    issue("remu_100_7", REMU,   32'd100,      32'd7,        32'd2,        33, 1);
    issue("div_100_m7", DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33, 1);
    issue("rem_100_m7", REM,    32'd100,      32'hFFFFFFF9, 32'd2,        33, 1);
    wait_drain();

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    mdOp = MUL; mdIn1 = 32'd3; mdIn2 = 32'd3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", 32'(busy), 32'd0);

    // Result held while out_ready is low.
    out_ready = 1'b0;
    issue("mul_hold", MUL, 32'd12345, 32'd100, 32'h0012D644, 33, 1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_mdout", mdOut, 32'h0012D644);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release_idle", 32'(in_ready), 32'd1);
    chk("hold_release_valid", 32'(out_valid), 32'd0);
    wait_drain();

    // Flush mid-divide, then a clean divide.
    issue("divu_flushed", DIVU, 32'd1000, 32'd10, 32'd0, 0, 0);
    repeat (12) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_calc_valid", 32'(out_valid), 32'd0);
    chk("flush_calc_busy", 32'(busy), 32'd0);
    chk("flush_calc_mdout", mdOut, 32'd0);
    issue("divu_after_flush", DIVU, 32'd1000, 32'd10, 32'd100, 33, 1);
    wait_drain();

    // Reset mid-divide with a request presented in the same cycle.
    issue("divu_reset", DIVU, 32'd1000, 32'd10, 32'd0, 0, 0);
    repeat (12) @(posedge clk);
    #1 rst = 1'b1; in_valid = 1'b1; mdOp = MUL; mdIn1 = 32'd5; mdIn2 = 32'd5;
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    chk("rst_calc_valid", 32'(out_valid), 32'd0);
    chk("rst_calc_busy", 32'(busy), 32'd0);
    chk("rst_calc_mdout", mdOut, 32'd0);
    issue("divu_after_rst", DIVU, 32'd1000, 32'd10, 32'd100, 33, 1);
    wait_drain();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
